ex_muldiv_seq: RTL

Multi-cycle sequencer for RV32M multiply/divide in the EX stage. It accepts an operation and forwarded operands from EX, stalls the pipeline while an iterative shift-add / restoring-divide datapath runs, and returns a one-cycle result for EX to place in the ALU-result slot. A pipeline flush (branch mispredict or trap) kills any in-flight operation.

---
 rtl/ex_muldiv_seq_pkg.sv | 36 +++
 rtl/ex_muldiv_seq_if.sv | 19 +
 rtl/ex_muldiv_seq_step.sv | 42 ++++
 rtl/ex_muldiv_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_seq_pkg.sv
// Shared definitions for the RV32M multi-cycle multiply/divide sequencer:
// operation encoding (RV32M funct3 order), FSM state codes and the
// architecturally defined divide special-case constants.
package ex_muldiv_seq_pkg;

  localparam int unsigned MULDIV_XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef logic [1:0] muldiv_state_t;
  localparam muldiv_state_t ST_IDLE = 2'd0;
  localparam muldiv_state_t ST_CALC = 2'd1;
  localparam muldiv_state_t ST_FIX  = 2'd2;
  localparam muldiv_state_t ST_DONE = 2'd3;

  localparam logic [31:0] DIV0_QUOT    = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_DIVIDEND = 32'h8000_0000;
  localparam logic [31:0] OVF_DIVISOR  = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_QUOT     = 32'h8000_0000;
  localparam logic [31:0] OVF_REM      = 32'h0000_0000;

  // Two's-complement negation modulo 2^32.
  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

endpackage

// File: rtl/ex_muldiv_seq_if.sv
// EX <-> muldiv sequencer bus.
//   master (EX side): drives flush, start, op, a, b; sees stall_o, done_o, result_o
//   slave (sequencer): the reverse
interface ex_muldiv_seq_if;
  import ex_muldiv_seq_pkg::*;

  logic        flush;
  logic        start;
  muldiv_op_t  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;

  modport master (output flush, start, op, a, b, input stall_o, done_o, result_o);
  modport slave  (input flush, start, op, a, b, output stall_o, done_o, result_o);

endinterface

// File: rtl/ex_muldiv_seq_step.sv
// Combinational iteration block: UNROLL shift-add (multiply) or
// restoring trial-subtract (divide) steps on the 64-bit accumulator.
//   is_div : 1 = divide step, 0 = multiply step
//   acc_i  : multiply {product_hi, multiplier}; divide {remainder, dividend/quotient}
//   opnd   : multiplicand or divisor magnitude
//   acc_o  : accumulator after UNROLL steps
module ex_muldiv_seq_step
#(
  parameter int unsigned UNROLL = 1
) (
  input  logic        is_div,
  input  logic [63:0] acc_i,
  input  logic [31:0] opnd,
  output logic [63:0] acc_o
);

  logic [63:0] acc;
  logic [32:0] t;

  always_comb begin
    acc = acc_i;
    t   = '0;
    for (int unsigned i = 0; i < UNROLL; i++) begin
      if (is_div) begin
        // Shift the next dividend bit into the remainder, keep the difference if it fits.
        t = {acc[63:32], acc[31]};
        if (t >= {1'b0, opnd}) begin
          t   = t - {1'b0, opnd};
          acc = {t[31:0], acc[30:0], 1'b1};
        end else begin
          acc = {t[31:0], acc[30:0], 1'b0};
        end
      end else begin
        // Add multiplicand on LSB of multiplier, then shift the product right.
        t   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        acc = {t, acc[31:1]};
      end
    end
    acc_o = acc;
  end

endmodule

// File: rtl/ex_muldiv_seq.sv
// RV32M multi-cycle multiply/divide sequencer for the EX stage.
// Operates on operand magnitudes and fixes the sign in a final FIX cycle.
//   clk, rst (async, active-low)
//   bus.slave : flush, start, op, a, b in; stall_o (combinational),
//               done_o (one-cycle pulse), result_o out
// Optional: define DIVREM_CACHE_EN to reuse the last divide's quotient and
// remainder for a following DIV/REM pair with identical operands.
module ex_muldiv_seq
  import ex_muldiv_seq_pkg::*;
#(
  parameter int unsigned UNROLL = 1
) (
  input logic              clk,
  input logic              rst,
  ex_muldiv_seq_if.slave   bus
);

  localparam int unsigned N     = MULDIV_XLEN / UNROLL;
  localparam int unsigned CNT_W = $clog2(MULDIV_XLEN);

  muldiv_state_t    state_q, state_d;
  muldiv_op_t       op_q;
  logic             sa_q, sb_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      opnd_q, result_q;
  logic [63:0]      acc_q, step_acc;
  logic             stall_c;

  // Cycle-0 decode of the incoming instruction.
  logic        accept, in_div, in_rem, a_sgn, b_sgn, sa_in, sb_in;
  logic        div_zero, div_ovf, special, cache_hit, fast;
  logic [31:0] abs_a, abs_b, sp_quot, sp_rem, cache_res, fast_res;

  assign accept   = bus.start && !bus.flush;
  assign in_div   = bus.op[2];
  assign in_rem   = bus.op[1];
  assign a_sgn    = bus.op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign b_sgn    = bus.op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  assign sa_in    = a_sgn & bus.a[31];
  assign sb_in    = b_sgn & bus.b[31];
  assign abs_a    = sa_in ? neg32(bus.a) : bus.a;
  assign abs_b    = sb_in ? neg32(bus.b) : bus.b;
  assign div_zero = (bus.b == '0);
  assign div_ovf  = (bus.op inside {OP_DIV, OP_REM}) && (bus.a == OVF_DIVIDEND) &&
                    (bus.b == OVF_DIVISOR);
  assign special  = in_div && (div_zero || div_ovf);
  assign sp_quot  = div_zero ? DIV0_QUOT : OVF_QUOT;
  assign sp_rem   = div_zero ? bus.a : OVF_REM;
  assign fast     = special || cache_hit;
  assign fast_res = cache_hit ? cache_res : (in_rem ? sp_rem : sp_quot);

  ex_muldiv_seq_step #(.UNROLL(UNROLL)) u_muldiv_step (
    .is_div (op_q[2]),
    .acc_i  (acc_q),
    .opnd   (opnd_q),
    .acc_o  (step_acc)
  );

  // Sign fix-up and result selection for the FIX cycle.
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix, res_fix;

  assign prod_fix = (sa_q ^ sb_q) ? (~acc_q + 64'd1) : acc_q;
  assign quot_fix = (sa_q ^ sb_q) ? neg32(acc_q[31:0]) : acc_q[31:0];
  assign rem_fix  = sa_q ? neg32(acc_q[63:32]) : acc_q[63:32];

  always_comb begin
    res_fix = rem_fix;
    case (op_q)
      OP_MUL:                       res_fix = prod_fix[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res_fix = prod_fix[63:32];
      OP_DIV, OP_DIVU:              res_fix = quot_fix;
      default:                      res_fix = rem_fix;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next state and stall.
  always_comb begin
    state_d = state_q;
    stall_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          stall_c = 1'b1;
          state_d = fast ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        stall_c = 1'b1;
        if (cnt_q == '0) state_d = ST_FIX;
      end
      ST_FIX: begin
        stall_c = 1'b1;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (bus.flush) state_d = ST_IDLE;
  end

  // Operand latch, iteration and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= OP_MUL;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      cnt_q    <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q  <= bus.op;
            sa_q  <= sa_in;
            sb_q  <= sb_in;
            cnt_q <= CNT_W'(N - 1);
            if (in_div) begin
              acc_q  <= {32'd0, abs_a};
              opnd_q <= abs_b;
            end else begin
              acc_q  <= {32'd0, abs_b};
              opnd_q <= abs_a;
            end
            if (fast) result_q <= fast_res;
          end
        end
        ST_CALC: begin
          acc_q <= step_acc;
          cnt_q <= cnt_q - CNT_W'(1);
        end
        ST_FIX: begin
          if (!bus.flush) result_q <= res_fix;
        end
        default: ;
      endcase
    end
  end

`ifdef DIVREM_CACHE_EN
  // Last divide-class result; written only when the op is certain to reach DONE.
  logic        c_valid, c_sgn;
  logic [31:0] c_a, c_b, c_quot, c_rem, a_q, b_q;

  assign cache_hit = c_valid && in_div && (bus.a == c_a) && (bus.b == c_b) &&
                     (c_sgn == ~bus.op[0]);
  assign cache_res = in_rem ? c_rem : c_quot;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_valid <= 1'b0;
      c_sgn   <= 1'b0;
      c_a     <= '0;
      c_b     <= '0;
      c_quot  <= '0;
      c_rem   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      if (state_q == ST_IDLE && accept) begin
        a_q <= bus.a;
        b_q <= bus.b;
      end
      if (state_q == ST_IDLE && accept && special) begin
        c_valid <= 1'b1;
        c_sgn   <= ~bus.op[0];
        c_a     <= bus.a;
        c_b     <= bus.b;
        c_quot  <= sp_quot;
        c_rem   <= sp_rem;
      end else if (state_q == ST_FIX && !bus.flush && op_q[2]) begin
        c_valid <= 1'b1;
        c_sgn   <= ~op_q[0];
        c_a     <= a_q;
        c_b     <= b_q;
        c_quot  <= quot_fix;
        c_rem   <= rem_fix;
      end
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_res = '0;
`endif

  assign bus.stall_o  = stall_c & rst;
  assign bus.done_o   = (state_q == ST_DONE);
  assign bus.result_o = result_q;

endmodule
